// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the memory stage: icode values, word width,
// the data-memory requester state encoding and the decoded access descriptor.
package y86_pkg;

    localparam int DATA_W = 64;

    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } dmem_state_t;

    typedef enum logic {
        ADDR_VALE = 1'b0,
        ADDR_VALA = 1'b1
    } addr_sel_t;

    typedef enum logic {
        WDATA_VALA = 1'b0,
        WDATA_VALP = 1'b1
    } wdata_sel_t;

    typedef struct packed {
        logic       is_access;
        logic       is_write;
        addr_sel_t  addr_sel;
        wdata_sel_t wdata_sel;
    } access_t;

endpackage

// File: rtl/dmem_requester_if.sv
// Valid/ready request channel plus read-response channel between the memory
// stage (master) and a multi-cycle data memory (slave).
interface dmem_requester_if #(
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );
endinterface

// File: rtl/dmem_access_decode.sv
// Combinational icode decode: whether the instruction touches data memory,
// the direction, and which execute-stage values supply address and store data.
module dmem_access_decode
    import y86_pkg::*;
(
    input  logic [3:0] i_icode,
    output access_t    o_access
);

    always_comb begin
        // NOTE: assign a full default first so every icode path drives o_access and no latch is inferred.
        o_access = '{is_access: 1'b0, is_write: 1'b0, addr_sel: ADDR_VALE, wdata_sel: WDATA_VALA};
        case (i_icode)
            IRMMOVQ, IPUSHQ: begin
                o_access.is_access = 1'b1;
                o_access.is_write  = 1'b1;
            end
            ICALL: begin
                o_access.is_access = 1'b1;
                o_access.is_write  = 1'b1;
                o_access.wdata_sel = WDATA_VALP;
            end
            IMRMOVQ: begin
                o_access.is_access = 1'b1;
            end
            IRET, IPOPQ: begin
                o_access.is_access = 1'b1;
                o_access.addr_sel  = ADDR_VALA;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/dmem_requester.sv
// Y86-64 memory-stage initiator: issues loads/stores over a valid/ready channel,
// returns valM, stalls upstream while busy. Optional macro: DMEM_TIMEOUT_EN.
module dmem_requester
    import y86_pkg::*;
#(
    parameter int DATA_W    = y86_pkg::DATA_W,
    parameter int MEM_WORDS = 1024
`ifdef DMEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 15
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valP,
    dmem_requester_if.master  mem,
    output logic              out_valid,
    output logic [DATA_W-1:0] valM,
    output logic              dmem_error
);

    dmem_state_t       r_state;
    logic              r_in_ready;
    logic              r_req_valid;
    logic              r_req_write;
    logic [DATA_W-1:0] r_req_addr;
    logic [DATA_W-1:0] r_req_wdata;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_valM;
    logic              r_dmem_error;

    access_t           w_acc;
    logic [DATA_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_accept;
    logic              w_addr_ok;

    dmem_access_decode u_decode (
        .i_icode  (icode),
        .o_access (w_acc)
    );

    assign w_addr    = (w_acc.addr_sel == ADDR_VALA) ? valA : valE;
    assign w_wdata   = (w_acc.wdata_sel == WDATA_VALP) ? valP : valA;
    assign w_accept  = in_valid && r_in_ready;
    // Unsigned full-width compare: huge addresses must not wrap into range.
    assign w_addr_ok = (w_addr < DATA_W'(MEM_WORDS));

`ifdef DMEM_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] r_timer;
    logic             w_timeout;

    // r_timer holds the number of WAIT cycles already elapsed before this one.
    assign w_timeout = (r_timer == TMR_W'(TIMEOUT - 1));
`endif

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
        if (rst) begin
            r_state      <= IDLE;
            r_in_ready   <= 1'b1;
            r_req_valid  <= 1'b0;
            r_req_write  <= 1'b0;
            r_req_addr   <= '0;
            r_req_wdata  <= '0;
            r_out_valid  <= 1'b0;
            r_valM       <= '0;
            r_dmem_error <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            r_timer      <= '0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (!w_acc.is_access) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end else if (!w_addr_ok) begin
                            r_state      <= ERR;
                            r_dmem_error <= 1'b1;
                        end else begin
                            r_state     <= REQ;
                            r_req_valid <= 1'b1;
                            r_req_write <= w_acc.is_write;
                            r_req_addr  <= w_addr;
                            r_req_wdata <= w_wdata;
                        end
                    end
                end
                REQ: begin
                    if (mem.req_ready) begin
                        r_req_valid <= 1'b0;
                        if (r_req_write) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= WAIT;
`ifdef DMEM_TIMEOUT_EN
                            r_timer <= '0;
`endif
                        end
                    end
                end
                WAIT: begin
                    // A response in the final allowed cycle still completes normally.
                    if (mem.rsp_valid) begin
                        r_valM      <= mem.rsp_rdata;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
`ifdef DMEM_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_dmem_error <= 1'b1;
                        r_state      <= ERR;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
`endif
                end
                DONE: begin
                    r_in_ready <= 1'b1;
                    r_state    <= IDLE;
                end
                ERR: begin
                    r_in_ready <= 1'b0;
                end
                default: begin
                    r_state <= ERR;
                end
            endcase
        end
    end

    assign in_ready      = r_in_ready;
    assign mem.req_valid = r_req_valid;
    assign mem.req_write = r_req_write;
    assign mem.req_addr  = r_req_addr;
    assign mem.req_wdata = r_req_wdata;
    assign out_valid     = r_out_valid;
    assign valM          = r_valM;
    assign dmem_error    = r_dmem_error;

endmodule

// File: doc/dmem_requester.md
Name: dmem_requester

Overview:
Initiator side of the data-memory interface for the Y86-64 memory stage.
- Takes icode/valE/valA/valP from execute and decides between load, store or no access.
- Drives a valid/ready request channel to a multi-cycle data memory, waits for read responses and returns valM to writeback.
- Stalls upstream while an access is outstanding.
- Flags dmem_error for out-of-range addresses.

Parameters:
- DATA_W, 64, width of data and address words.
- MEM_WORDS, 1024, number of addressable words; a valid address is < MEM_WORDS.
- TIMEOUT, 15, cycles allowed in WAIT before a timeout error (used only with DMEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  execute-stage bundle valid.
- in_ready  out  1  block can accept a bundle; upstream stall = !in_ready.
- icode  in  4  instruction code.
- valE  in  DATA_W  ALU result / effective address.
- valA  in  DATA_W  register A value.
- valP  in  DATA_W  next PC.
- req_valid  out  1  memory request valid.
- req_ready  in  1  memory accepts request.
- req_write  out  1  1 = store, 0 = load.
- req_addr  out  DATA_W  word address.
- req_wdata  out  DATA_W  store data.
- rsp_valid  in  1  load data valid.
- rsp_rdata  in  DATA_W  load data.
- out_valid  out  1  one-cycle pulse: access complete, valM valid.
- valM  out  DATA_W  loaded value, held until the next load completes.
- dmem_error  out  1  sticky memory error.

Behaviour:
Reset values: every output 0, except in_ready = 1 after reset is released. State returns to IDLE.

Access decode, latched on acceptance (in_valid && in_ready):
- 4 (rmmovq): store, addr valE, data valA.
- A (pushq): store, addr valE, data valA.
- 8 (call): store, addr valE, data valP.
- 5 (mrmovq): load, addr valE.
- 9 (ret): load, addr valA.
- B (popq): load, addr valA.
- All other icodes: no access.

States and transitions:
- IDLE: in_ready = 1. On acceptance:
  - no-access icode -> DONE;
  - address >= MEM_WORDS -> set dmem_error, go to ERR, no request issued;
  - otherwise -> REQ.
- REQ: req_valid = 1; req_write/req_addr/req_wdata come from registered values and stay stable until req_ready.
  - req_valid && req_ready: store -> DONE; load -> WAIT.
  - req_valid deasserts on the edge after the handshake.
- WAIT: on rsp_valid, register rsp_rdata into valM -> DONE.
- DONE: out_valid = 1 for exactly one cycle -> IDLE.
- ERR: in_ready = 0 permanently (processor halts); out_valid stays 0. Only rst exits.

Latency:
- No-access: accept at cycle N, out_valid at N+1.
- Store with req_ready high: req_valid at N+1, out_valid at N+2.
- Load: rsp_valid at cycle k gives out_valid at k+1, with valM updated on that same edge.

Boundary rules:
- rsp_valid outside WAIT is ignored. rsp_valid in the same cycle as the load handshake is not consumed.
- Address MEM_WORDS-1 is legal; address MEM_WORDS and above is an error.
- Comparison is unsigned over the full 64 bits.
- rst asserted mid-access: return to IDLE, drop req_valid on the same edge, clear dmem_error. valM is cleared to 0.
- in_valid while in_ready = 0 is not latched. Upstream holds the bundle.

Optional Feature:
DMEM_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. On reaching TIMEOUT without rsp_valid: set dmem_error, go to ERR. A response arriving in the same cycle the counter reaches TIMEOUT wins: normal completion, no error.
- Undefined: WAIT waits indefinitely; no counter is instantiated.

Decomposition:
- Shared package y86_pkg:
  - icode localparams (IRMMOVQ=4, IMRMOVQ=5, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B);
  - dmem state enum (IDLE, REQ, WAIT, DONE, ERR);
  - DATA_W.
- One natural sub-module, dmem_access_decode: combinational icode -> {is_access, is_write, addr_sel, wdata_sel}. The FSM and registers stay in the top module.

Test Plan:
- Store handshake: rmmovq, valE=0x10, valA=0xDEAD, req_ready held 0 for 3 cycles then 1 -> req_valid high 4 cycles with fields stable, req_write=1, addr 0x10, wdata 0xDEAD; out_valid pulses one cycle later; in_ready=0 throughout.
- Call: icode=8, valE=0x3F8, valP=0x42 -> req_wdata=0x42.
- Load: popq, valA=0x20; rsp_valid after 5 cycles with 0x1234 -> req_addr=0x20, req_write=0; valM=0x1234 with out_valid the next cycle; valM held afterwards.
- Address bounds: mrmovq valE=1023 -> request issued. mrmovq valE=1024 -> no req_valid, dmem_error=1, in_ready stuck at 0 until rst.
- Mid-access reset: rst during WAIT -> next cycle req_valid=0, in_ready=1, dmem_error=0. A late rsp_valid is ignored and produces no out_valid.
- No-access, then timeout: icode=6 -> out_valid at N+1, no request. With DMEM_TIMEOUT_EN and TIMEOUT=15, withhold the response -> dmem_error after exactly 15 WAIT cycles. A response in cycle 15 -> normal completion, no error.
